// File: rtl/frame_cmd_decoder_pkg.sv
// rtl/frame_cmd_decoder_pkg.sv - package frame_pkg: FSM states, marker bytes and WAIT_TX timeout
// FRAME_ACK_EN adds the RESP and WAIT_TX response states.
package frame_pkg;

  localparam logic [7:0] MARK_SET   = 8'd65;  // 'A'
  localparam logic [7:0] MARK_CLEAR = 8'd67;  // 'C'
  localparam logic [7:0] MARK_TOGGLE = 8'd84; // 'T'
  localparam logic [7:0] MARK_QUERY = 8'd81;  // 'Q'
  localparam logic [7:0] MARK_ACK   = 8'd75;  // 'K'
  localparam logic [7:0] MARK_ERR   = 8'd69;  // 'E'

  localparam int WAIT_TIMEOUT = 1024;
  localparam int TIMER_W      = $clog2(WAIT_TIMEOUT);

`ifdef FRAME_ACK_EN
  typedef enum logic [1:0] {IDLE, DECODE, RESP, WAIT_TX} state_t;
`else
  typedef enum logic [1:0] {IDLE, DECODE} state_t;
`endif

endpackage

// File: rtl/frame_cmd_decoder_if.sv
// rtl/frame_cmd_decoder_if.sv - RX frame / TX response handshake bundle for frame_cmd_decoder
interface frame_cmd_decoder_if #(
  parameter int DBITS       = 8,
  parameter int FRAME_BYTES = 4
);
  logic                         frame_valid;
  logic [DBITS*FRAME_BYTES-1:0] frame_in;
  logic                         tx_ready;
  logic                         tx_trigger;
  logic [DBITS*FRAME_BYTES-1:0] tx_frame;

  modport master (output frame_valid, frame_in, tx_ready, input tx_trigger, tx_frame);
  modport slave  (input frame_valid, frame_in, tx_ready, output tx_trigger, tx_frame);
endinterface

// File: rtl/sat_counter8.sv
// rtl/sat_counter8.sv - 8-bit incrementer that sticks at 255, synchronous clear
module sat_counter8 (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end
endmodule

// File: rtl/frame_cmd_decoder.sv
// rtl/frame_cmd_decoder.sv - decodes 4-byte flag command frames, updates flags, counts errors/drops
// FRAME_ACK_EN enables the response frame, tx_trigger and the RESP/WAIT_TX handshake.
module frame_cmd_decoder
  import frame_pkg::*;
#(
  parameter int DBITS       = 8,
  parameter int FRAME_BYTES = 4,
  parameter int FLAG_COUNT  = 8
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  frame_cmd_decoder_if.slave    bus,
  output logic [FLAG_COUNT-1:0] flags,
  output logic [7:0]            err_count,
  output logic [7:0]            drop_count,
  output logic                  busy
);

  localparam int FW    = DBITS * FRAME_BYTES;
  localparam int IDX_W = (FLAG_COUNT > 1) ? $clog2(FLAG_COUNT) : 1;

  state_t                  state;
  logic [FW-1:0]           frame_q;
  logic [DBITS-1:0]        b0, b1, b2, b3;
  logic                    cmd_known;
  logic                    frame_ok;
  logic [FLAG_COUNT-1:0]   flags_upd;

  assign b0 = frame_q[DBITS-1:0];
  assign b1 = frame_q[2*DBITS-1:DBITS];
  assign b2 = frame_q[3*DBITS-1:2*DBITS];
  assign b3 = frame_q[4*DBITS-1:3*DBITS];

  // Query skips the index range check but still needs the inverted index byte.
  always_comb begin
    cmd_known = (b0 == DBITS'(MARK_SET)) || (b0 == DBITS'(MARK_CLEAR)) ||
                (b0 == DBITS'(MARK_TOGGLE)) || (b0 == DBITS'(MARK_QUERY));
    frame_ok  = (b0 == b3) && cmd_known && (b2 == ~b1) &&
                ((b0 == DBITS'(MARK_QUERY)) || (32'(b1) < FLAG_COUNT));
    flags_upd = flags;
    if (b0 == DBITS'(MARK_SET)) begin
      flags_upd[b1[IDX_W-1:0]] = 1'b1;
    end else if (b0 == DBITS'(MARK_CLEAR)) begin
      flags_upd[b1[IDX_W-1:0]] = 1'b0;
    end else if (b0 == DBITS'(MARK_TOGGLE)) begin
      flags_upd[b1[IDX_W-1:0]] = ~flags[b1[IDX_W-1:0]];
    end
  end

`ifdef FRAME_ACK_EN
  logic [FW-1:0]      tx_frame_q;
  logic [TIMER_W-1:0] timer;
  logic               seen_low;
  logic [DBITS-1:0]   flags_byte;

  assign flags_byte = DBITS'(flags_upd);
`endif

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state   <= IDLE;
      frame_q <= '0;
      flags   <= '0;
`ifdef FRAME_ACK_EN
      tx_frame_q <= '0;
      timer      <= '0;
      seen_low   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.frame_valid) begin
            frame_q <= bus.frame_in;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (frame_ok) begin
            flags <= flags_upd;
          end
`ifdef FRAME_ACK_EN
          tx_frame_q <= frame_ok ? {b0, flags_byte, b1, DBITS'(MARK_ACK)}
                                 : {DBITS'(MARK_ERR), {DBITS{1'b0}}, b1, DBITS'(MARK_ERR)};
          state      <= RESP;
`else
          state <= IDLE;
`endif
        end
`ifdef FRAME_ACK_EN
        RESP: begin
          if (bus.tx_ready) begin
            state    <= WAIT_TX;
            timer    <= '0;
            seen_low <= 1'b0;
          end
        end
        // Leave on a low-then-high edge of tx_ready, or after a full timeout of it staying high.
        WAIT_TX: begin
          if (!bus.tx_ready) begin
            seen_low <= 1'b1;
            timer    <= '0;
          end else if (seen_low || (timer == TIMER_W'(WAIT_TIMEOUT - 1))) begin
            state <= IDLE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef FRAME_ACK_EN
  assign bus.tx_frame   = tx_frame_q;
  assign bus.tx_trigger = (state == RESP) && bus.tx_ready && !reset;
`else
  logic unused_tx_ready;
  assign unused_tx_ready = bus.tx_ready;
  assign bus.tx_frame    = '0;
  assign bus.tx_trigger  = 1'b0;
`endif

  sat_counter8 u_err_count (
    .clk   (clk_100MHz),
    .clr   (reset),
    .inc   ((state == DECODE) && !frame_ok),
    .count (err_count)
  );

  sat_counter8 u_drop_count (
    .clk   (clk_100MHz),
    .clr   (reset),
    .inc   (bus.frame_valid && (state != IDLE)),
    .count (drop_count)
  );

endmodule

// File: doc/frame_cmd_decoder.md
FRAME_CMD_DECODER -- requirements
Module: frame_cmd_decoder

Interface
REQ-001 The block SHALL have parameter DBITS, default 8, bits per UART byte.
REQ-002 The block SHALL have parameter FRAME_BYTES, default 4, bytes per received and transmitted frame; only 4 is supported.
REQ-003 The block SHALL have parameter FLAG_COUNT, default 8, number of flag bits, at most 2**DBITS.
REQ-004 clk_100MHz  input  1  sole clock; all logic on its rising edge; one clock; reset is synchronous and active-high.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 frame_valid  input  1  one-cycle pulse: frame_in holds a newly completed RX frame.
REQ-007 frame_in  input  DBITS*FRAME_BYTES  RX frame; byte0 = bits[7:0], byte3 = bits[31:24].
REQ-008 tx_ready  input  1  UART TX can accept a frame.
REQ-009 tx_trigger  output  1  one-cycle pulse: launch tx_frame.
REQ-010 tx_frame  output  DBITS*FRAME_BYTES  response frame, stable from tx_trigger until the next accepted frame.
REQ-011 flags  output  FLAG_COUNT  flag register.
REQ-012 err_count  output  8  saturating count of rejected frames.
REQ-013 drop_count  output  8  saturating count of frames ignored while busy.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 A valid frame SHALL satisfy all of: byte0 == byte3, byte0 in {65 'A' set, 67 'C' clear, 84 'T' toggle, 81 'Q' query}, byte2 == ~byte1, and byte1 < FLAG_COUNT; 'Q' SHALL ignore the byte1 range check but not the byte2 check.
REQ-016 The FSM SHALL have states IDLE, DECODE, RESP, and WAIT_TX.
REQ-017 In IDLE, frame_valid SHALL latch frame_in and move the FSM to DECODE on the next edge.
REQ-018 DECODE SHALL take exactly one cycle.
REQ-019 If the frame is valid, DECODE SHALL apply set, clear, or toggle to flags[byte1], leave flags unchanged for 'Q', and build tx_frame = {byte3=byte0, byte2=flags after update (zero-extended or truncated to DBITS), byte1=byte1, byte0=75 'K'}.
REQ-020 If the frame is invalid, DECODE SHALL leave flags unchanged, increment err_count with saturation at 255, and build tx_frame = {69 'E', 8'h00, byte1, 69 'E'}.
REQ-021 DECODE SHALL then go to RESP.
REQ-022 In RESP, when tx_ready=1, the block SHALL assert tx_trigger for exactly that cycle and go to WAIT_TX; otherwise it SHALL remain in RESP indefinitely.
REQ-023 WAIT_TX SHALL return to IDLE on the first cycle tx_ready=0 is followed by tx_ready=1, or after 1024 cycles of tx_ready staying 1, whichever comes first.
REQ-024 Latency SHALL be: frame_valid at cycle N gives tx_trigger at cycle N+2 when tx_ready is held at 1.
REQ-025 frame_valid outside IDLE SHALL be ignored and SHALL increment drop_count with saturation at 255.
REQ-026 frame_valid in the same cycle the FSM enters IDLE from WAIT_TX SHALL count as a drop.
REQ-027 Flag updates SHALL occur only in DECODE.

Reset
REQ-028 On reset the FSM SHALL go to IDLE and flags, err_count, drop_count, tx_frame, tx_trigger, and busy SHALL all be 0.
REQ-029 Reset mid-operation SHALL abandon the pending frame with no tx_trigger, and the next frame_valid after reset deasserts SHALL be accepted.

Configuration
REQ-030 With macro FRAME_ACK_EN defined, response behaviour SHALL be as in REQ-019 to REQ-023.
REQ-031 With FRAME_ACK_EN undefined, DECODE SHALL go directly to IDLE, tx_trigger SHALL be tied 0, tx_frame SHALL be tied 0, and the RESP and WAIT_TX states and timer SHALL be absent; flag and counter behaviour SHALL be unchanged.

Structure
REQ-032 A shared package frame_pkg SHALL hold the state enum, the marker constants (65, 67, 84, 81, 75, 69), and the WAIT_TX timeout constant (1024).
REQ-033 One sub-module, sat_counter8 (8-bit saturating incrementer with synchronous clear), SHALL be instantiated twice, for err_count and drop_count.

Verification
REQ-034 Frame {65,0xFE,0x01,65} (byte3..byte0) with tx_ready=1 -> flags=0x02, tx_trigger at N+2, tx_frame={65,0x02,0x01,75}.
REQ-035 After REQ-034, frame {67,0xFE,0x01,67} -> flags=0x00 and tx_frame={67,0x00,0x01,75}; then {84,0xF8,0x07,84} twice -> flags 0x80 then 0x00.
REQ-036 Frame {67,0xFE,0x01,65} (mismatched markers) -> flags unchanged, err_count=1, tx_frame={69,0x00,0x01,69}; index 9 with byte2=0xF6 -> err_count=2.
REQ-037 Hold tx_ready=0 for 50 cycles after a valid frame, then inject a second frame_valid -> drop_count=1, no tx_trigger until tx_ready rises, then exactly one tx_trigger.
REQ-038 Assert reset while in RESP -> no tx_trigger and all outputs 0; 300 invalid frames -> err_count saturates at 255.
REQ-039 Build without FRAME_ACK_EN and apply the REQ-034 frame -> flags=0x02, tx_trigger never asserts, and busy is high for 1 cycle.
